// File: rtl/id_hazard_controller.sv
// ============================================================================
// Module   : id_hazard_controller
// Brief    : ID-stage sequencing for RV32IM: load-use stall, branch flush and
//            multi-cycle M-extension hold. M support built only when
//            HAZARD_MULDIV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_hazard_controller #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       id_valid,
    input  logic       id_muldiv,
    input  logic       id_is_div,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_branch_taken,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_bubble,
    output logic       ex_hold,
    output logic       md_start,
    output logic       md_busy
);

    logic w_lu_hazard;

    assign w_lu_hazard = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                         ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                          (id_uses_rs2 & (id_rs2 == ex_rd)));

    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_flush;
    logic w_id_ex_bubble;
    logic w_ex_hold;
    logic w_md_start;
    logic w_md_busy;

`ifdef HAZARD_MULDIV_EN
    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // Counter is preloaded with N-2 so the busy window lasts N-1 cycles.
    localparam logic [5:0] c_mul_reload = (MUL_CYCLES > 1) ? 6'(MUL_CYCLES - 2) : 6'd0;
    localparam logic [5:0] c_div_reload = (DIV_CYCLES > 1) ? 6'(DIV_CYCLES - 2) : 6'd0;
    localparam logic       c_mul_multi  = (MUL_CYCLES > 1);
    localparam logic       c_div_multi  = (DIV_CYCLES > 1);

    state_t     r_state;
    logic [5:0] r_cnt;
    logic       w_issue;
    logic       w_multi;

    assign w_issue = ~ex_branch_taken & ~w_lu_hazard & id_valid & id_muldiv;
    assign w_multi = id_is_div ? c_div_multi : c_mul_multi;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= ST_RUN;
            r_cnt   <= 6'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue && w_multi) begin
                        r_state <= ST_MD_BUSY;
                        r_cnt   <= id_is_div ? c_div_reload : c_mul_reload;
                    end
                end
                ST_MD_BUSY: begin
                    if (r_cnt == 6'd0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_hold      = 1'b0;
        w_md_start     = 1'b0;
        w_md_busy      = 1'b0;
        if (r_state == ST_MD_BUSY) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_ex_hold     = 1'b1;
            w_md_busy     = 1'b1;
        end else if (ex_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_lu_hazard) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (id_valid && id_muldiv) begin
            w_md_start = 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_unused = ^{CLK, id_muldiv, id_is_div, 32'(MUL_CYCLES), 32'(DIV_CYCLES)};

    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_hold      = 1'b0;
        w_md_start     = 1'b0;
        w_md_busy      = 1'b0;
        if (ex_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_lu_hazard) begin
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end
    end
`endif

    // Outputs are combinational from inputs, so reset must mask them directly.
    assign pc_stall     = w_pc_stall     & RESETn;
    assign if_id_stall  = w_if_id_stall  & RESETn;
    assign if_id_flush  = w_if_id_flush  & RESETn;
    assign id_ex_bubble = w_id_ex_bubble & RESETn;
    assign ex_hold      = w_ex_hold      & RESETn;
    assign md_start     = w_md_start     & RESETn;
    assign md_busy      = w_md_busy      & RESETn;

endmodule

`default_nettype wire

// File: doc/id_hazard_controller.md
# id_hazard_controller

Pipeline sequencing controller for the RV32IM core, sitting beside the ID stage. It detects load-use hazards on the instruction in ID and inserts a single-cycle stall. It flushes IF/ID and bubbles ID/EX when EX resolves a taken branch or jump. It holds the front of the pipeline for the full occupancy of multi-cycle M-extension operations in EX.

## Interface
Parameters:
- MUL_CYCLES, default 2: EX occupancy of MUL/MULH/MULHSU/MULHU, in cycles (legal range 1..63).
- DIV_CYCLES, default 33: EX occupancy of DIV/DIVU/REM/REMU, in cycles (legal range 1..63).

Ports:
- CLK, input, 1: sole clock, rising edge.
- RESETn, input, 1: asynchronous, active-low reset.
- id_rs1, input, 5: rs1 field of the instruction in ID.
- id_rs2, input, 5: rs2 field of the instruction in ID.
- id_uses_rs1, input, 1: the instruction in ID reads rs1.
- id_uses_rs2, input, 1: the instruction in ID reads rs2.
- id_valid, input, 1: ID holds a real (non-bubble) instruction.
- id_muldiv, input, 1: the instruction in ID is an M-extension op.
- id_is_div, input, 1: the M op in ID is a divide or remainder.
- ex_rd, input, 5: destination register of the instruction in EX.
- ex_mem_read, input, 1: the instruction in EX is a load.
- ex_branch_taken, input, 1: EX redirects the PC this cycle.
- pc_stall, output, 1: hold the PC.
- if_id_stall, output, 1: hold the IF/ID register.
- if_id_flush, output, 1: clear IF/ID to a bubble at the next edge.
- id_ex_bubble, output, 1: load a bubble into ID/EX at the next edge.
- ex_hold, output, 1: hold EX/ID-EX contents; the M unit keeps iterating.
- md_start, output, 1: one-cycle pulse launching the M unit.
- md_busy, output, 1: a multi-cycle M op occupies EX.

## Operation
States:
- RUN: normal flow.
- MD_BUSY: a multi-cycle M op occupies EX.
- 6-bit down-counter `cnt`.

Hazard definition:
- lu_hazard = id_valid & ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).

RUN, evaluated combinationally, priority highest first:
1. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, no stall, md_start=0. The M op in ID is discarded and no state change occurs.
2. lu_hazard: pc_stall=1, if_id_stall=1, id_ex_bubble=1. The next cycle re-evaluates; the load has advanced, so the hazard clears.
3. id_valid & id_muldiv: md_start=1 and the op enters EX at the edge. With N = id_is_div ? DIV_CYCLES : MUL_CYCLES:
   - N > 1: next state MD_BUSY, cnt <= N-2.
   - N = 1: stay in RUN.
4. Otherwise all outputs are 0.

MD_BUSY:
- pc_stall=1, if_id_stall=1, ex_hold=1, md_busy=1. if_id_flush, id_ex_bubble and md_start are 0.
- ex_branch_taken, lu_hazard and id_muldiv are ignored.
- cnt == 0: next state RUN. Otherwise cnt <= cnt-1.
- Stall length is exactly N-1 cycles after the md_start cycle.

Reset:
- RESETn low forces RUN and cnt=0 immediately, without waiting for a clock edge.
- All outputs are 0 while reset is held.
- Reset mid-MD_BUSY abandons the op; the M unit is reset by the same RESETn.

## Timing
- Hazard, flush and start outputs are combinational from the current state and inputs (zero latency). They are valid before the edge at which the pipeline registers act.
- State and cnt are registered.
- Back-to-back M ops: the second issues in the first RUN cycle after MD_BUSY exits, with no gap cycle.
- A load-use hazard on an M op costs 1 stall cycle; md_start follows in the next cycle.

## Configuration
- HAZARD_MULDIV_EN defined: full behaviour as above.
- HAZARD_MULDIV_EN undefined:
  - id_muldiv and id_is_div are ignored.
  - MD_BUSY and cnt are not synthesized.
  - md_start, md_busy and ex_hold are tied to 0.
  - The block reduces to the load-use and branch-flush logic (RV32I-only core).

## Test plan
- lw x5 in EX (ex_mem_read=1, ex_rd=5), add reading rs1=5 in ID -> one cycle with pc_stall=if_id_stall=id_ex_bubble=1, then all 0.
- ex_rd=0 load with id_rs1=0 -> no stall. Load to x5 with id_uses_rs2=0, id_rs2=5 -> no stall.
- ex_branch_taken=1 together with lu_hazard=1 -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
- DIV issued with DIV_CYCLES=33 -> md_start high 1 cycle, then md_busy/ex_hold/pc_stall high exactly 32 cycles, then RUN. MUL with MUL_CYCLES=2 -> exactly 1 busy cycle.
- ex_branch_taken=1 during MD_BUSY -> ignored, no flush. Back-to-back DIV, DIV -> second md_start in the cycle right after the first busy window ends.
- RESETn pulsed low in cycle 10 of MD_BUSY -> all outputs 0 asynchronously. After release, state is RUN and a new MUL issues normally.
